spram_fifo_ctrl: RTL and testbench
==================================

// Module: spram_fifo_ctrl
// PURPOSE
//   Valid/ready FIFO controller that time-shares one single-port synchronous RAM (one access per cycle,
//   read or write) between the push side and the pop side. Arbitrates per cycle, owns the pointers and
//   occupancy, and prefetches RAM data into a 2-entry output buffer so m_valid/m_data come from registers.
//   Sits between an upstream valid/ready producer and a downstream consumer. The spram instance is external.
// PARAMETERS
//   DATA_WIDTH  8                        payload width
//   FIFO_DEPTH  16                       RAM entries, >=2, need not be a power of 2
//   ADDR_WIDTH  $clog2(FIFO_DEPTH)       RAM address width
//   CNT_WIDTH   $clog2(FIFO_DEPTH+4)     occupancy width (localparam)
// PORTS
//   clk       in   1           clock
//   rst_n     in   1           synchronous reset, active low
//   s_valid   in   1           upstream data valid
//   s_ready   out  1           upstream ready
//   s_data    in   DATA_WIDTH  upstream payload
//   m_valid   out  1           downstream data valid
//   m_ready   in   1           downstream ready
//   m_data    out  DATA_WIDTH  downstream payload (head of output buffer)
//   ram_en    out  1           RAM access this cycle
//   ram_we    out  1           RAM write (1) / read (0)
//   ram_addr  out  ADDR_WIDTH  RAM address
//   ram_din   out  DATA_WIDTH  RAM write data (= s_data)
//   ram_dout  in   DATA_WIDTH  RAM read data = ram[address registered on previous edge]
//   count     out  CNT_WIDTH   total entries held: ram_cnt + rd_inflight + out_cnt
//   empty     out  1           count == 0
//   full      out  1           ram_cnt == FIFO_DEPTH
// BEHAVIOUR
//   State: wr_ptr, rd_ptr (0..FIFO_DEPTH-1, wrap to 0 after FIFO_DEPTH-1), ram_cnt (0..FIFO_DEPTH),
//     rd_inflight (1b), out_cnt (0..2) with 2-entry output FIFO, pri (0=READ, 1=WRITE).
//   Reset (rst_n=0 at edge): all state 0, pri=READ. While rst_n=0: s_ready=0, m_valid=0, ram_en=0, ram_we=0.
//     Reset mid-operation discards all contents; RAM array not cleared. First push accepted cycle after release.
//   want_rd = (ram_cnt!=0) && (out_cnt + rd_inflight < 2)  -- registered state only, no m_ready term.
//   s_ready = !full && !(want_rd && pri==READ)  -- depends on registered state only, never on s_valid/m_ready.
//   grant_wr = s_valid && s_ready;  grant_rd = want_rd && !grant_wr.  Never both in one cycle.
//   pri: in a cycle with want_rd && s_valid && !full, pri <= (grant_rd ? WRITE : READ); else unchanged.
//     Guarantees each side >= every other cycle under contention.
//   RAM drive: ram_en = grant_wr|grant_rd; ram_we = grant_wr; ram_addr = grant_wr ? wr_ptr : rd_ptr.
//   Read latency: read issued cycle t -> ram_dout valid cycle t+1, captured into output buffer at end of
//     t+1 (rd_inflight marks this). RAM registers address every cycle regardless of ram_en, so capture must
//     occur only in the cycle right after grant_rd; ram_dout is ignored at all other times.
//   grant_wr: RAM write, wr_ptr++ (wrap), ram_cnt++.  grant_rd: rd_ptr++ (wrap), ram_cnt--, rd_inflight<=1.
//   Output: m_valid = out_cnt!=0; pop when m_valid && m_ready; capture and pop may coincide (out_cnt
//     unchanged, order preserved). out_cnt+rd_inflight<=2 guarantees capture never overflows.
//   Push-to-m_valid latency on idle FIFO: push cycle t, read t+1, capture t+2, m_valid at t+3.
//   Full: s_ready=0 when ram_cnt==FIFO_DEPTH, even if a read is issued that cycle (no same-cycle refill).
//   Empty: no read issued when ram_cnt==0; m_valid/m_data held stable while m_valid && !m_ready.
//   Total capacity = FIFO_DEPTH + 2 (RAM + output buffer). Data order strictly FIFO.
// TESTING
//   1 Reset, push 0xA5 at cycle t, m_ready=1 -> ram_we at t, read at t+1, m_valid=1 m_data=0xA5 at t+3, count 0 after pop.
//   2 Push 0..17 with m_ready=0 -> 16 in RAM + 2 in output buffer interleaved; full=1, s_ready=0, count=18;
//     then drain with m_ready=1 -> 0..17 in order, no loss/duplication.
//   3 Continuous s_valid and m_ready with FIFO half full -> ram_en every cycle, writes/reads alternate
//     (pri toggles), s_ready toggles 1,0,1,0; ordering preserved.
//   4 Pointer wrap: FIFO_DEPTH=5, stream 23 words with random m_ready/s_valid -> scoreboard match, ram_addr 0..4 only.
//   5 m_ready held 0 while m_valid=1 for 10 cycles -> m_data stable; random push stalls -> no ram_en when idle.
//   6 Assert rst_n=0 with 7 entries held and read in flight -> next cycle count=0, m_valid=0, s_ready=0; after release, fresh data only.

Source files
------------

// File: rtl/spram_fifo_ctrl_if.sv
// Valid/ready handshake bundle for the single-port-RAM FIFO controller.
// master drives the push side and accepts from the pop side; slave is the FIFO.
interface spram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller time-sharing one single-port synchronous RAM between push
// and pop. Reads are prefetched into a 2-entry register buffer so the pop
// side sees registered m_valid/m_data. Capacity is FIFO_DEPTH + 2.
module spram_fifo_ctrl #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 4)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spram_fifo_ctrl_if.slave      bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full
);

  typedef enum logic {
    PRI_READ  = 1'b0,
    PRI_WRITE = 1'b1
  } pri_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

  pri_t                  pri_q, pri_d;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  ram_cnt;
  logic                  rd_inflight;
  logic [1:0]            out_cnt;
  logic [DATA_WIDTH-1:0] out_buf0, out_buf1;
  logic                  want_rd, s_ready_i, grant_wr, grant_rd, pop;

  // Request/grant terms; s_ready depends on registered state only so it
  // never combinationally follows s_valid or m_ready.
  assign full      = (ram_cnt == DEPTH_CNT);
  assign want_rd   = (ram_cnt != '0) && ((3'(out_cnt) + 3'(rd_inflight)) < 3'd2);
  assign s_ready_i = rst_n && !full && !(want_rd && (pri_q == PRI_READ));
  assign grant_wr  = bus.s_valid && s_ready_i;
  assign grant_rd  = rst_n && want_rd && !grant_wr;

  assign bus.s_ready = s_ready_i;
  assign bus.m_valid = rst_n && (out_cnt != 2'd0);
  assign bus.m_data  = out_buf0;
  assign pop         = bus.m_valid && bus.m_ready;

  assign ram_en   = grant_wr || grant_rd;
  assign ram_we   = grant_wr;
  assign ram_addr = grant_wr ? wr_ptr : rd_ptr;
  assign ram_din  = bus.s_data;

  assign count = ram_cnt + CNT_WIDTH'(rd_inflight) + CNT_WIDTH'(out_cnt);
  assign empty = (count == '0);

  // Arbitration priority: flips to the loser whenever both sides contend.
  always_comb begin
    pri_d = pri_q;
    if (want_rd && bus.s_valid && !full) begin
      pri_d = grant_rd ? PRI_WRITE : PRI_READ;
    end
  end

  // Priority state register.
  always_ff @(posedge clk) begin
    if (!rst_n) pri_q <= PRI_READ;
    else        pri_q <= pri_d;
  end

  // Pointers, occupancy, read-in-flight tracking and the output buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      out_cnt     <= 2'd0;
      out_buf0    <= '0;
      out_buf1    <= '0;
    end else begin
      if (grant_wr) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
      if (grant_rd) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_WIDTH'(1);
      case ({grant_wr, grant_rd})
        2'b10:   ram_cnt <= ram_cnt + CNT_WIDTH'(1);
        2'b01:   ram_cnt <= ram_cnt - CNT_WIDTH'(1);
        default: ;
      endcase
      // ram_dout is only meaningful the cycle after a read grant.
      rd_inflight <= grant_rd;
      // Capture lands behind any held entry; a simultaneous pop shifts
      // the buffer first so order is kept with out_cnt unchanged.
      case ({rd_inflight, pop})
        2'b10: begin
          if (out_cnt == 2'd0) out_buf0 <= ram_dout;
          else                 out_buf1 <= ram_dout;
          out_cnt <= out_cnt + 2'd1;
        end
        2'b01: begin
          out_buf0 <= out_buf1;
          out_cnt  <= out_cnt - 2'd1;
        end
        2'b11: begin
          if (out_cnt == 2'd1) begin
            out_buf0 <= ram_dout;
          end else begin
            out_buf0 <= out_buf1;
            out_buf1 <= ram_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl: a 16-deep and a 5-deep instance, each with a
// behavioural RAM. Stimulus records accepted words in a queue; monitors pop
// and compare whenever the DUT hands a word downstream.
module tb_spram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n, rst5_n;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting, got no event expected one at %0t", name, $time);
  endtask

  // ---------------- 16-deep instance ----------------
  spram_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();
  logic       ram_en, ram_we, full, empty;
  logic [3:0] ram_addr, addr_q;
  logic [7:0] ram_din, ram_dout;
  logic [4:0] count;
  logic [7:0] mem [16];

  spram_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .count(count), .empty(empty), .full(full)
  );

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    addr_q <= ram_addr;
  end
  assign ram_dout = mem[addr_q];

  logic [7:0] exp_q [$];
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = '0;

  // Scoreboard/monitor: occupancy is simply words accepted minus words popped.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready", 32'(bus.s_ready), 0);
      chk("rst_m_valid", 32'(bus.m_valid), 0);
      chk("rst_ram_en", 32'(ram_en), 0);
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      if (exp_q.size() == 18) begin
        chk("full_at_cap", 32'(full), 1);
        chk("s_ready_at_cap", 32'(bus.s_ready), 0);
      end
      chk("write_is_push", 32'(ram_en && ram_we), 32'(bus.s_valid && bus.s_ready));
      if (!bus.s_valid && exp_q.size() == 0) chk("idle_no_ram_en", 32'(ram_en), 0);
      if (hold_prev) begin
        chk("stall_m_valid", 32'(bus.m_valid), 1);
        chk("stall_m_data", 32'(bus.m_data), 32'(data_prev));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 32'(bus.m_data), 32'hFFFF_FFFF);
        else chk("pop_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
      if (bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
      hold_prev = bus.m_valid && !bus.m_ready;
      data_prev = bus.m_data;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int unsigned n = 0;
    logic done = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!done) begin
      @(negedge clk);
      done = bus.s_ready;
      n++;
      next_cycle();
      if (!done && n > 60) begin
        timeout("push");
        done = 1'b1;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    logic done = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = (count == 5'd0);
    end
    if (!done) timeout("drain");
    next_cycle();
  endtask

  task automatic rand_phase(input int unsigned cycles, input int unsigned pv, input int unsigned pr);
    logic acc;
    for (int c = 0; c < int'(cycles); c++) begin
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      next_cycle();
      if (acc || !bus.s_valid) begin
        bus.s_valid = ($urandom_range(0, 99) < pv);
        bus.s_data  = 8'($urandom);
      end
      bus.m_ready = ($urandom_range(0, 99) < pr);
    end
  endtask

  // ---------------- 5-deep instance (pointer wrap) ----------------
  spram_fifo_ctrl_if #(.DATA_WIDTH(8)) bus5 ();
  logic       ram5_en, ram5_we, full5, empty5;
  logic [2:0] ram5_addr, addr5_q;
  logic [7:0] ram5_din, ram5_dout;
  logic [3:0] count5;
  logic [7:0] mem5 [8];
  logic [7:0] q5 [$];
  int unsigned rx5 = 0;
  logic done5 = 1'b0;

  spram_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst5_n), .bus(bus5),
    .ram_en(ram5_en), .ram_we(ram5_we), .ram_addr(ram5_addr), .ram_din(ram5_din),
    .ram_dout(ram5_dout), .count(count5), .empty(empty5), .full(full5)
  );

  always @(posedge clk) begin
    if (ram5_en && ram5_we) mem5[ram5_addr] <= ram5_din;
    addr5_q <= ram5_addr;
  end
  assign ram5_dout = mem5[addr5_q];

  always @(negedge clk) begin
    if (rst5_n) begin
      chk("d5_count", 32'(count5), 32'(q5.size()));
      if (ram5_en) chk("d5_addr_range", 32'(ram5_addr < 3'd5), 1);
      if (bus5.m_valid && bus5.m_ready) begin
        rx5++;
        if (q5.size() == 0) chk("d5_pop_unexpected", 32'(bus5.m_data), 32'hFFFF_FFFF);
        else chk("d5_pop_data", 32'(bus5.m_data), 32'(q5.pop_front()));
      end
      if (bus5.s_valid && bus5.s_ready) q5.push_back(bus5.s_data);
    end
  end

  initial begin
    int unsigned sent = 0;
    logic acc;
    rst5_n = 1'b0;
    bus5.s_valid = 1'b0;
    bus5.s_data  = '0;
    bus5.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst5_n = 1'b1;
    for (int c = 0; c < 2000 && !(sent == 23 && q5.size() == 0); c++) begin
      @(negedge clk);
      acc = bus5.s_valid && bus5.s_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (acc || !bus5.s_valid) begin
        bus5.s_valid = (sent < 23) && ($urandom_range(0, 99) < 60);
        bus5.s_data  = 8'($urandom);
      end
      bus5.m_ready = ($urandom_range(0, 99) < 50);
    end
    chk("d5_words_sent", sent, 23);
    chk("d5_words_received", rx5, 23);
    done5 = 1'b1;
  end

  // ---------------- main sequence on the 16-deep instance ----------------
  initial begin
    logic acc, prev_sr, seen;
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_count", 32'(count), 0);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_s_ready", 32'(bus.s_ready), 1);
    next_cycle();

    // Single word latency: write at t, read t+1, visible at t+3.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("lat_t_ram_en", 32'(ram_en), 1);
    chk("lat_t_ram_we", 32'(ram_we), 1);
    next_cycle();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_read", 32'({ram_en, ram_we}), 32'b10);
    chk("lat_t1_addr", 32'(ram_addr), 0);
    @(negedge clk);
    chk("lat_t2_m_valid", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("lat_t3_m_valid", 32'(bus.m_valid), 1);
    chk("lat_t3_m_data", 32'(bus.m_data), 32'hA5);
    next_cycle();
    @(negedge clk);
    chk("lat_count_after_pop", 32'(count), 0);
    next_cycle();

    // Fill to capacity with the consumer stalled, then drain in order.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 18; i++) push(8'(i));
    repeat (4) next_cycle();
    @(negedge clk);
    chk("cap_full", 32'(full), 1);
    chk("cap_s_ready", 32'(bus.s_ready), 0);
    chk("cap_count", 32'(count), 18);
    next_cycle();
    drain();

    // Contention: continuous push and pop alternate RAM ownership.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    bus.s_valid = 1'b1;
    bus.s_data  = 8'($urandom);
    bus.m_ready = 1'b1;
    prev_sr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      if (c >= 8) begin
        chk("alt_ram_en", 32'(ram_en), 1);
        chk("alt_s_ready", 32'(bus.s_ready), 32'(!prev_sr));
      end
      prev_sr = bus.s_ready;
      next_cycle();
      if (acc) bus.s_data = 8'($urandom);
    end
    drain();

    // Consumer stall with m_valid held, then random push/pop stalls.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    repeat (10) next_cycle();
    rand_phase(300, 60, 50);
    drain();
    rand_phase(200, 30, 80);
    drain();

    // Reset with words held and a read in flight.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    repeat (3) next_cycle();
    bus.m_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = ram_en && !ram_we;
      next_cycle();
      bus.m_ready = 1'b0;
    end
    if (!seen) timeout("read_before_reset");
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_m_valid", 32'(bus.m_valid), 0);
    chk("mid_rst_s_ready", 32'(bus.s_ready), 0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    drain();

    for (int c = 0; c < 5000 && !done5; c++) next_cycle();
    if (!done5) timeout("d5_stream");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
